// File: rtl/bsg_transpose_stream_pkg.sv
// rtl/bsg_transpose_stream_pkg.sv - shared types and sizing helper for the transpose stream
package bsg_transpose_stream_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;

  // Row counters need at least one bit even for the smallest legal matrix.
  function automatic int cnt_width(input int els);
    return (els > 2) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_transpose_stream_bank.sv
// rtl/bsg_transpose_stream_bank.sv - one matrix buffer: row write port, row or column read
module bsg_transpose_stream_bank #(
  parameter int width_p = 1,
  parameter int els_p   = 16,
  parameter int cnt_w_p = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [cnt_w_p-1:0]       wrow_i,
  input  logic [els_p*width_p-1:0] wdata_i,
  input  logic [cnt_w_p-1:0]       rrow_i,
  input  logic                     transpose_i,
  output logic [els_p*width_p-1:0] rdata_o
);

  logic [els_p*width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[wrow_i] <= wdata_i;
  end

  // Constant-index selection keeps every part-select static for synthesis.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < els_p; k++) begin
      if (rrow_i == cnt_w_p'(k)) begin
        for (int j = 0; j < els_p; j++) begin
          rdata_o[j*width_p +: width_p] = transpose_i ? mem[j][k*width_p +: width_p]
                                                      : mem[k][j*width_p +: width_p];
        end
      end
    end
  end

endmodule

// File: rtl/bsg_transpose_stream.sv
// rtl/bsg_transpose_stream.sv - double-buffered streaming matrix transposer with pass-through mode
module bsg_transpose_stream
  import bsg_transpose_stream_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic                     mode_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [els_p*width_p-1:0] data_o,
  output logic                     mode_o,
  output logic                     last_o,
  output logic                     v_o,
  input  logic                     yumi_i
);

  localparam int cnt_w_lp = cnt_width(els_p);
  localparam logic [cnt_w_lp-1:0] last_row_lp = cnt_w_lp'(els_p - 1);

  bank_state_e          state_r [2];
  logic                 mode_r  [2];
  logic                 wb_r, rb_r;
  logic [cnt_w_lp-1:0]  wr_r, rr_r;
  logic [els_p*width_p-1:0] bank_data [2];
  logic                 in_xfer, out_xfer;

  assign ready_o  = (state_r[wb_r] != FULL) & reset_n_i;
  assign v_o      = (state_r[rb_r] == FULL);
  assign in_xfer  = v_i & ready_o;
  assign out_xfer = yumi_i & v_o;

  assign data_o = v_o ? bank_data[rb_r] : '0;
  assign mode_o = v_o & mode_r[rb_r];
  assign last_o = v_o & (rr_r == last_row_lp);

  // Write and read always target different banks when both are active.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wb_r <= 1'b0;
      rb_r <= 1'b0;
      wr_r <= '0;
      rr_r <= '0;
      for (int b = 0; b < 2; b++) begin
        state_r[b] <= EMPTY;
        mode_r[b]  <= 1'b0;
      end
    end else begin
      if (in_xfer) begin
        if (wr_r == '0) begin
          state_r[wb_r] <= FILLING;
          mode_r[wb_r]  <= mode_i;
        end
        if (wr_r == last_row_lp) begin
          state_r[wb_r] <= FULL;
          wr_r          <= '0;
          wb_r          <= ~wb_r;
        end else begin
          wr_r <= wr_r + cnt_w_lp'(1);
        end
      end
      if (out_xfer) begin
        if (rr_r == last_row_lp) begin
          state_r[rb_r] <= EMPTY;
          rr_r          <= '0;
          rb_r          <= ~rb_r;
        end else begin
          rr_r <= rr_r + cnt_w_lp'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bsg_transpose_stream_bank #(
      .width_p (width_p),
      .els_p   (els_p),
      .cnt_w_p (cnt_w_lp)
    ) u_bank (
      .clk_i       (clk_i),
      .we_i        (in_xfer & (wb_r == 1'(b))),
      .wrow_i      (wr_r),
      .wdata_i     (data_i),
      .rrow_i      (rr_r),
      .transpose_i (mode_r[b]),
      .rdata_o     (bank_data[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
  end

endmodule

// File: tb/tb_bsg_transpose_stream.sv
// tb/tb_bsg_transpose_stream.sv - directed self-checking bench for bsg_transpose_stream
module tb_bsg_transpose_stream;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic [31:0] data_i, data_o;
  logic        mode_i, v_i, ready_o, mode_o, last_o, v_o, yumi_i;

  logic [15:0] big_data_i, big_data_o;
  logic        big_v_i, big_ready_o, big_mode_o, big_last_o, big_v_o, big_yumi_i;

  int total = 0, passed = 0, failed = 0;

  logic [31:0] rows  [4] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
  logic [31:0] trows [4] = '{32'h30201000, 32'h31211101, 32'h32221202, 32'h33231303};

  logic [31:0] in_q[$], exp_q[$];
  bit          in_mode_q[$], exp_mode_q[$];
  int          first_cyc, end_cyc;

  always #5 clk = ~clk;

  bsg_transpose_stream #(.width_p(8), .els_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .mode_i(mode_i), .v_i(v_i),
    .ready_o(ready_o), .data_o(data_o), .mode_o(mode_o), .last_o(last_o), .v_o(v_o),
    .yumi_i(yumi_i));

  bsg_transpose_stream #(.width_p(1), .els_p(16)) dut_big (
    .clk_i(clk), .reset_n_i(reset_n_i), .data_i(big_data_i), .mode_i(1'b1), .v_i(big_v_i),
    .ready_o(big_ready_o), .data_o(big_data_o), .mode_o(big_mode_o), .last_o(big_last_o),
    .v_o(big_v_o), .yumi_i(big_yumi_i));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_matrix(input logic [31:0] ofs, input bit mode);
    for (int r = 0; r < 4; r++) begin
      in_q.push_back(rows[r] + ofs);
      in_mode_q.push_back(mode);
      exp_q.push_back((mode ? trows[r] : rows[r]) + ofs);
      exp_mode_q.push_back(mode);
    end
  endtask

  // Feeds in_q, consumes every valid row, compares against exp_q.
  task automatic run(input string tag, input bit strict, input int ready_chk, input int max_cyc);
    int ii = 0, oo = 0, cyc = 0;
    first_cyc = -1;
    while ((ii < in_q.size() || oo < exp_q.size()) && cyc < max_cyc) begin
      v_i    = (ii < in_q.size());
      data_i = v_i ? in_q[ii] : 32'h0;
      mode_i = v_i ? in_mode_q[ii] : 1'b0;
      #1;
      yumi_i = v_o;
      if (strict && v_i) check({tag, "_ready"}, ready_o, 1'b1);
      if (ready_chk >= 0 && v_i) check({tag, "_ready_ret"}, ready_o, cyc >= ready_chk);
      if (strict && oo > 0 && oo < exp_q.size()) check({tag, "_nobubble"}, v_o, 1'b1);
      if (v_o) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (oo < exp_q.size()) begin
          check($sformatf("%s_data%0d", tag, oo), data_o, exp_q[oo]);
          check($sformatf("%s_mode%0d", tag, oo), mode_o, exp_mode_q[oo]);
          check($sformatf("%s_last%0d", tag, oo), last_o, (oo % 4) == 3);
        end else begin
          check({tag, "_extra_row"}, v_o, 1'b0);
        end
        oo++;
      end
      if (v_i && ready_o) ii++;
      step();
      cyc++;
    end
    end_cyc = cyc;
    check({tag, "_all_in"}, ii, in_q.size());
    check({tag, "_all_out"}, oo, exp_q.size());
    v_i = 1'b0;
    yumi_i = 1'b0;
    #1;
    check({tag, "_idle_after"}, v_o, 1'b0);
    in_q.delete(); in_mode_q.delete(); exp_q.delete(); exp_mode_q.delete();
  endtask

  task automatic run_big(input string tag);
    logic [255:0] in_vec, out_vec, exp_vec;
    int ii = 0, oo = 0, cyc = 0;
    for (int r = 0; r < 16; r++) in_vec[r*16 +: 16] = 16'($urandom);
    out_vec = '0;
    while (oo < 16 && cyc < 100) begin
      big_v_i    = (ii < 16);
      big_data_i = big_v_i ? in_vec[ii*16 +: 16] : 16'h0;
      #1;
      big_yumi_i = big_v_o;
      if (big_v_o) begin
        out_vec[oo*16 +: 16] = big_data_o;
        oo++;
      end
      if (big_v_i && big_ready_o) ii++;
      step();
      cyc++;
    end
    big_v_i = 1'b0;
    big_yumi_i = 1'b0;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        exp_vec[k*16 + j] = in_vec[j*16 + k];
    check({tag, "_rows"}, oo, 16);
    check({tag, "_bits"}, out_vec, exp_vec);
  endtask

  initial begin
    reset_n_i = 1'b0;
    data_i = '0; mode_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    big_data_i = '0; big_v_i = 1'b0; big_yumi_i = 1'b0;
    step();
    check("rst_v_o", v_o, 1'b0);
    check("rst_ready_o", ready_o, 1'b0);
    check("rst_last_o", last_o, 1'b0);
    check("rst_mode_o", mode_o, 1'b0);
    check("rst_data_o", data_o, 32'h0);
    step();
    reset_n_i = 1'b1;
    #1;
    check("post_rst_ready", ready_o, 1'b1);
    step();

    add_matrix(32'h0, 1'b1);
    run("xpose", 1'b1, -1, 50);
    check("xpose_latency", first_cyc, 4);

    add_matrix(32'h0, 1'b0);
    run("pass", 1'b1, -1, 50);
    check("pass_latency", first_cyc, 4);

    // Backpressure: fill both banks with the consumer stalled.
    v_i = 1'b1; mode_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_i = rows[i % 4] + ((i / 4) * 32'h40404040);
      #1;
      check($sformatf("bp_fill_ready%0d", i), ready_o, 1'b1);
      step();
    end
    data_i = rows[0] + 32'h80808080;
    #1;
    check("bp_full_ready", ready_o, 1'b0);
    check("bp_full_v_o", v_o, 1'b1);
    step();
    check("bp_stall_ready", ready_o, 1'b0);
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(trows[r]); exp_mode_q.push_back(1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(trows[r] + 32'h40404040); exp_mode_q.push_back(1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      in_q.push_back(rows[r] + 32'h80808080); in_mode_q.push_back(1'b1);
      exp_q.push_back(trows[r] + 32'h80808080); exp_mode_q.push_back(1'b1);
    end
    run("bp_drain", 1'b0, 4, 60);

    for (int m = 0; m < 10; m++) add_matrix(m * 32'h01010101, (m % 2) == 0);
    run("sustain", 1'b1, -1, 100);
    check("sustain_first", first_cyc, 4);
    check("sustain_end", end_cyc, 44);

    // Reset with one full bank pending and a partial matrix in the other.
    v_i = 1'b1; mode_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_i = rows[i % 4] + 32'h20202020;
      step();
    end
    v_i = 1'b0;
    #1;
    check("pre_rst_v_o", v_o, 1'b1);
    reset_n_i = 1'b0;
    #1;
    check("midrst_v_o", v_o, 1'b0);
    check("midrst_ready", ready_o, 1'b0);
    check("midrst_data", data_o, 32'h0);
    step();
    reset_n_i = 1'b1;
    #1;
    check("midrst_rel_ready", ready_o, 1'b1);
    check("midrst_rel_v_o", v_o, 1'b0);
    step();
    add_matrix(32'h80808080, 1'b1);
    run("fresh", 1'b1, -1, 50);
    check("fresh_latency", first_cyc, 4);

    run_big("big0");
    run_big("big1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bsg_transpose_stream.md
Name: bsg_transpose_stream

Overview:
Streaming, double-buffered matrix transposer. It accepts a square els_p x els_p matrix of width_p-bit elements one row per handshake and emits the transposed matrix one row per handshake. Each matrix can instead select pass-through mode, which emits its rows unchanged. It sits between row-oriented producers and column-oriented consumers, with one-row-per-cycle sustained throughput in both directions.

Parameters:
- width_p, 1: bits per matrix element.
- els_p, 16: matrix dimension (rows = columns = els_p); must be >= 2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- data_i  in  els_p*width_p  input row; element e at bits [e*width_p +: width_p].
- mode_i  in  1  1 = transpose, 0 = pass-through; sampled only with row 0 of each matrix.
- v_i  in  1  input row valid.
- ready_o  out  1  block can accept a row; input transfer = v_i & ready_o.
- data_o  out  els_p*width_p  output row, same element packing as data_i.
- mode_o  out  1  mode of the matrix currently being drained.
- last_o  out  1  high with the final row (row els_p-1) of a matrix.
- v_o  out  1  output row valid.
- yumi_i  in  1  consumer takes the row; legal only when v_o=1.

Behaviour:
- Storage: two banks, each holding els_p rows plus a mode bit. Each bank has state EMPTY -> FILLING -> FULL -> EMPTY.
- Write side: write-bank pointer wb and row counter wr (log2(els_p) bits).
  - On each input transfer, store data_i in row wr of bank wb.
  - When wr=0, also capture mode_i into the bank's mode bit and set the bank to FILLING.
  - When wr=els_p-1: set the bank to FULL, reset wr to 0, and toggle wb.
- ready_o = (bank[wb] != FULL) & reset_n_i.
- Read side: read-bank pointer rb and row counter rr.
  - v_o = (bank[rb] == FULL).
  - On yumi_i, increment rr. When rr=els_p-1: set the bank to EMPTY, reset rr to 0, and toggle rb.
- Output data:
  - Transpose mode: element j of output row k = element k of input row j.
  - Pass-through mode: output row k = input row k.
  - data_o = 0 when v_o=0.
- last_o = v_o & (rr == els_p-1).
- mode_o = mode bit of bank rb when v_o=1, else 0.
- Latency: row 0 of the output is valid in the cycle after the input transfer of row els_p-1. No bubble between back-to-back matrices when both sides run every cycle.
- Simultaneous events:
  - Write to bank wb and read from bank rb in the same cycle is always legal (rb != wb whenever both are active).
  - Draining the last row of bank X and writing row 0 into bank X in the same cycle cannot occur: ready_o was 0 for X that cycle. The write happens the following cycle.
- Full condition: both banks FULL gives ready_o=0, and input stalls with no data loss. Empty condition: v_o=0.
- Counter wrap: counters run modulo els_p; for non-power-of-2 els_p, compare explicitly against els_p-1.
- Protocol errors (yumi_i while v_o=0): ignored, no state change; a simulation assertion fires.
- Reset, including mid-matrix:
  - wb, rb, wr, rr = 0; both banks EMPTY; stored partial matrices are discarded.
  - Outputs during reset: v_o=0, ready_o=0, last_o=0, mode_o=0, data_o=0.
  - ready_o=1 in the first cycle after reset deasserts.
- Bank contents themselves are not reset.

Decomposition:
- Package bsg_transpose_stream_pkg: bank state enum (EMPTY, FILLING, FULL) and a function that computes the row-counter width from els_p.
- One sub-module, bsg_transpose_stream_bank: els_p x els_p x width_p register array with a row-write port and a combinational read of row k (pass-through) or column k (transpose). It is instantiated twice; the top holds the counters, pointers and bank state.

Test Plan (width_p=8, els_p=4 unless noted):
- Single transpose matrix: mode_i=1; rows 0x03020100, 0x13121110, 0x23222120, 0x33323130; yumi_i held at 1 -> outputs 0x30201000, 0x31211101, 0x32221202, 0x33231303 with last_o on the 4th. First v_o comes 1 cycle after the 4th input transfer.
- Pass-through: same rows with mode_i=0 -> outputs identical to inputs in order; mode_o=0 on every output row.
- Back-to-back and backpressure:
  - Three matrices with yumi_i=0 -> ready_o drops after 8 accepted rows; 9th row stalls.
  - Then yumi_i=1 continuously -> all 12 rows emerge correct; ready_o returns 1 the cycle after the first bank drains.
- Sustained throughput: v_i=1 and yumi_i=1 for 10 matrices -> ready_o never 0 after the first cycle; exactly one output row per cycle once started.
- Reset mid-operation:
  - reset_n_i pulsed low after 2 rows of a matrix and with one FULL bank pending -> v_o=0 immediately.
  - After release, the next 4 rows form a fresh matrix and no stale rows appear.
- Scaling: width_p=1, els_p=16 with random 256-bit matrices -> output bit (k*16+j) equals input bit (j*16+k) for all j, k.
